// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller family: FSM encoding,
// mcause layout and the channel-id width helper.
package irq_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } irq_state_e;

  localparam int MCAUSE_INT_BIT = 31;

  // Width of a channel index; never narrower than one bit.
  function automatic int irq_id_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_ctrl_pri_if.sv
// Core-side and peripheral-side signals of irq_ctrl_pri, bundled so that the
// controller, the CSR unit and a bench share one definition.
interface irq_ctrl_pri_if #(
  parameter int N_IRQ = 16
);
  logic [N_IRQ-1:0] mie_i;
  logic [N_IRQ-1:0] int_req_i;
  logic             INT_RST_i;
  logic             INT_o;
  logic [31:0]      mcause_o;
  logic [N_IRQ-1:0] int_fin_o;
  logic [N_IRQ-1:0] pending_o;
  logic             busy_o;

  modport master (
    output mie_i, int_req_i, INT_RST_i,
    input  INT_o, mcause_o, int_fin_o, pending_o, busy_o
  );

  modport slave (
    input  mie_i, int_req_i, INT_RST_i,
    output INT_o, mcause_o, int_fin_o, pending_o, busy_o
  );
endinterface

// File: rtl/irq_arbiter.sv
// Combinational N-way arbiter: fixed priority (lowest index) or round-robin
// starting at ptr and wrapping at N_IRQ-1.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int N_IRQ = 16,
  parameter int IW    = irq_id_w(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic             rr,
  output logic             vld,
  output logic [IW-1:0]    id
);

  int k;

  // Walk offsets from the far end so the nearest hit is the last one written.
  always_comb begin
    vld = 1'b0;
    id  = '0;
    k   = 0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      k = rr ? ((int'(ptr) + i) % N_IRQ) : i;
      if (req[k]) begin
        vld = 1'b1;
        id  = IW'(k);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl_pri.sv
// Parametrised interrupt controller: per-channel level/edge capture, masking,
// fixed or round-robin arbitration and a single in-service slot toward the core.
module irq_ctrl_pri
  import irq_pkg::*;
#(
  parameter int               N_IRQ      = 16,
  parameter int               CAUSE_BASE = 16,
  parameter int               RR_MODE    = 0,
  parameter logic [N_IRQ-1:0] EDGE_MASK  = '0
) (
  input logic           clk,
  input logic           rst_i,
  irq_ctrl_pri_if.slave bus
);

  localparam int IW = irq_id_w(N_IRQ);

  if (N_IRQ < 1 || N_IRQ > 32) begin : g_bad_n
    $error("irq_ctrl_pri: N_IRQ must be 1..32");
  end
  if ((64'(CAUSE_BASE) + 64'(N_IRQ) - 64'd1) >= 64'h8000_0000) begin : g_bad_cause
    $error("irq_ctrl_pri: CAUSE_BASE+N_IRQ-1 exceeds mcause code field");
  end

  irq_state_e       state, nstate;
  logic [IW-1:0]    id_q, ptr_q, win_id;
  logic             win_vld, grant, done, int_q;
  logic [31:0]      mcause_q, mcause_d;
  logic [N_IRQ-1:0] pending, elig, fin;

  // Edge channels latch until their own completion; level channels follow the line.
  for (genvar c = 0; c < N_IRQ; c++) begin : g_ch
    if (EDGE_MASK[c]) begin : g_edge
      logic req_q, pend_q;
      always_ff @(posedge clk) begin
        if (rst_i) begin
          req_q  <= 1'b0;
          pend_q <= 1'b0;
        end else begin
          req_q  <= bus.int_req_i[c];
          pend_q <= (bus.int_req_i[c] & ~req_q) | (pend_q & ~fin[c]);
        end
      end
      assign pending[c] = pend_q;
    end else begin : g_lvl
      assign pending[c] = bus.int_req_i[c];
    end
  end

  assign elig = pending & bus.mie_i;

  irq_arbiter #(.N_IRQ(N_IRQ), .IW(IW)) u_arb (
    .req (elig),
    .ptr (ptr_q),
    .rr  (RR_MODE != 0),
    .vld (win_vld),
    .id  (win_id)
  );

  always_comb begin
    nstate = state;
    grant  = 1'b0;
    done   = 1'b0;
    case (state)
      IDLE: if (win_vld) begin
        grant  = 1'b1;
        nstate = ACTIVE;
      end
      ACTIVE: if (bus.INT_RST_i && !rst_i) begin
        done   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    fin       = '0;
    fin[id_q] = done;
  end

  always_comb begin
    mcause_d                 = '0;
    mcause_d[30:0]           = 31'(CAUSE_BASE) + 31'(win_id);
    mcause_d[MCAUSE_INT_BIT] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state    <= IDLE;
      id_q     <= '0;
      ptr_q    <= '0;
      int_q    <= 1'b0;
      mcause_q <= '0;
    end else begin
      state <= nstate;
      int_q <= grant;
      if (grant) begin
        id_q     <= win_id;
        mcause_q <= mcause_d;
      end
      // Pointer moves past the channel just serviced so it loses next round.
      if (done && RR_MODE != 0)
        ptr_q <= (int'(id_q) == N_IRQ - 1) ? '0 : id_q + IW'(1);
    end
  end

  assign bus.INT_o     = int_q;
  assign bus.busy_o    = (state == ACTIVE);
  assign bus.mcause_o  = mcause_q;
  assign bus.int_fin_o = fin;
  assign bus.pending_o = pending;

endmodule

// File: tb/tb_irq_ctrl_pri.sv
// Directed bench: a fixed-priority instance with channel 7 edge-triggered and
// a round-robin all-level instance, stepped through hand-computed vectors.
module tb_irq_ctrl_pri;
  logic clk = 1'b0;
  logic rst_i;
  int   nerr = 0;
  int   nchk = 0;

  always #5 clk = ~clk;

  irq_ctrl_pri_if #(.N_IRQ(16)) bf ();
  irq_ctrl_pri_if #(.N_IRQ(16)) br ();

  irq_ctrl_pri #(.N_IRQ(16), .CAUSE_BASE(16), .RR_MODE(0), .EDGE_MASK(16'h0080)) u_fix (
    .clk (clk), .rst_i (rst_i), .bus (bf)
  );
  irq_ctrl_pri #(.N_IRQ(16), .CAUSE_BASE(16), .RR_MODE(1), .EDGE_MASK(16'h0000)) u_rr (
    .clk (clk), .rst_i (rst_i), .bus (br)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; combinational outputs are
  // checked after a further 1ns settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_r[4];
    exp_r = '{0, 2, 0, 2};
    rst_i = 1'b1;
    bf.mie_i = '0; bf.int_req_i = '0; bf.INT_RST_i = 1'b0;
    br.mie_i = '0; br.int_req_i = '0; br.INT_RST_i = 1'b0;
    tick(); tick();
    chk("rst_busy",   32'(bf.busy_o),    32'd0);
    chk("rst_int",    32'(bf.INT_o),     32'd0);
    chk("rst_mcause", bf.mcause_o,       32'd0);
    chk("rst_fin",    32'(bf.int_fin_o), 32'd0);
    chk("rst_pend",   32'(bf.pending_o), 32'd0);
    rst_i = 1'b0;
    tick();

    // fixed priority, level 0x0028 -> channel 3
    bf.mie_i = 16'hFFFF; bf.int_req_i = 16'h0028; #1;
    chk("lvl_pend", 32'(bf.pending_o), 32'h0028);
    tick();
    chk("lvl_int1",   32'(bf.INT_o),  32'd1);
    chk("lvl_busy",   32'(bf.busy_o), 32'd1);
    chk("lvl_mcause", bf.mcause_o,    32'h8000_0013);
    tick();
    chk("lvl_int_pulse", 32'(bf.INT_o),  32'd0);
    chk("lvl_busy2",     32'(bf.busy_o), 32'd1);
    bf.INT_RST_i = 1'b1; #1;
    chk("lvl_fin", 32'(bf.int_fin_o), 32'h0008);
    tick();
    bf.INT_RST_i = 1'b0; bf.int_req_i = '0; #1;
    chk("lvl_fin_off", 32'(bf.int_fin_o), 32'd0);
    chk("lvl_idle",    32'(bf.busy_o),    32'd0);
    tick();
    chk("lvl_noint",     32'(bf.INT_o), 32'd0);
    chk("mcause_hold",   bf.mcause_o,   32'h8000_0013);

    // completion request while idle is ignored
    bf.INT_RST_i = 1'b1; #1;
    chk("idle_rst_fin", 32'(bf.int_fin_o), 32'd0);
    tick();
    bf.INT_RST_i = 1'b0;
    chk("idle_rst_busy", 32'(bf.busy_o), 32'd0);
    chk("idle_rst_int",  32'(bf.INT_o),  32'd0);

    // masked channel 4, then unmask
    bf.mie_i = 16'hFFEF; bf.int_req_i = 16'h0010; #1;
    chk("mask_pend", 32'(bf.pending_o), 32'h0010);
    tick();
    chk("mask_noint", 32'(bf.INT_o),  32'd0);
    chk("mask_idle",  32'(bf.busy_o), 32'd0);
    bf.mie_i = 16'hFFFF;
    tick();
    chk("unmask_int",    32'(bf.INT_o), 32'd1);
    chk("unmask_mcause", bf.mcause_o,   32'h8000_0014);
    bf.INT_RST_i = 1'b1; bf.int_req_i = '0; #1;
    chk("first_cycle_fin", 32'(bf.int_fin_o), 32'h0010);
    tick();
    bf.INT_RST_i = 1'b0;
    chk("first_cycle_idle", 32'(bf.busy_o), 32'd0);

    // edge ch7 pulses while ch1 in service
    bf.int_req_i = 16'h0002;
    tick();
    chk("ch1_int",    32'(bf.INT_o), 32'd1);
    chk("ch1_mcause", bf.mcause_o,   32'h8000_0011);
    bf.int_req_i = 16'h0082;
    tick();
    bf.int_req_i = 16'h0002; #1;
    chk("edge_latched", 32'(bf.pending_o), 32'h0082);
    tick();
    chk("edge_held", 32'(bf.pending_o), 32'h0082);
    chk("edge_busy", 32'(bf.busy_o),    32'd1);
    bf.int_req_i = '0; bf.INT_RST_i = 1'b1; #1;
    chk("ch1_fin_after_drop", 32'(bf.int_fin_o), 32'h0002);
    tick();
    bf.INT_RST_i = 1'b0;
    chk("edge_gap_int",  32'(bf.INT_o),     32'd0);
    chk("edge_gap_pend", 32'(bf.pending_o), 32'h0080);
    tick();
    chk("edge_int",    32'(bf.INT_o), 32'd1);
    chk("edge_mcause", bf.mcause_o,   32'h8000_0017);

    // re-edge in the completion cycle: set wins
    bf.int_req_i = 16'h0080; bf.INT_RST_i = 1'b1; #1;
    chk("reedge_fin", 32'(bf.int_fin_o), 32'h0080);
    tick();
    bf.INT_RST_i = 1'b0; #1;
    chk("reedge_pend", 32'(bf.pending_o), 32'h0080);
    chk("reedge_idle", 32'(bf.busy_o),    32'd0);
    tick();
    chk("reedge_int",    32'(bf.INT_o), 32'd1);
    chk("reedge_mcause", bf.mcause_o,   32'h8000_0017);
    bf.int_req_i = '0; bf.INT_RST_i = 1'b1; #1;
    chk("reedge_fin2", 32'(bf.int_fin_o), 32'h0080);
    tick();
    bf.INT_RST_i = 1'b0; #1;
    chk("reedge_clear", 32'(bf.pending_o), 32'd0);

    // reset during ACTIVE drops service and edge pending
    bf.int_req_i = 16'h0081;
    tick();
    chk("pre_rst_busy", 32'(bf.busy_o),    32'd1);
    chk("pre_rst_pend", 32'(bf.pending_o), 32'h0081);
    rst_i = 1'b1; bf.int_req_i = '0; bf.INT_RST_i = 1'b1; #1;
    chk("rst_act_nofin", 32'(bf.int_fin_o), 32'd0);
    tick();
    rst_i = 1'b0; bf.INT_RST_i = 1'b0; #1;
    chk("rst_act_busy",   32'(bf.busy_o),    32'd0);
    chk("rst_act_mcause", bf.mcause_o,       32'd0);
    chk("rst_act_pend",   32'(bf.pending_o), 32'd0);
    tick();
    chk("rst_act_noint", 32'(bf.INT_o), 32'd0);

    // req 0x0005 held: round-robin alternates 0,2; fixed stays on 0
    bf.mie_i = 16'hFFFF; bf.int_req_i = 16'h0005;
    br.mie_i = 16'hFFFF; br.int_req_i = 16'h0005;
    for (int s = 0; s < 4; s++) begin
      tick();
      chk("rr_int",     32'(br.INT_o), 32'd1);
      chk("rr_mcause",  br.mcause_o,   32'h8000_0010 + 32'(exp_r[s]));
      chk("fix_mcause", bf.mcause_o,   32'h8000_0010);
      br.INT_RST_i = 1'b1; bf.INT_RST_i = 1'b1; #1;
      chk("rr_fin",  32'(br.int_fin_o), 32'd1 << exp_r[s]);
      chk("fix_fin", 32'(bf.int_fin_o), 32'h0001);
      tick();
      br.INT_RST_i = 1'b0; bf.INT_RST_i = 1'b0;
      chk("rr_idle", 32'(br.busy_o), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
